// File: rtl/target_pkg.sv
// rtl/target_pkg.sv - shared FSM state type, LFSR constants and default playfield bounds
// Optional feature macro used by the top: TARGET_AVOID_HEAD_EN
package target_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GEN   = 2'd1,
    ST_ARMED = 2'd2,
    ST_HIT   = 2'd3
  } state_t;

  localparam int              LFSR_W    = 16;
  // Taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

  localparam int X_MAX_DEF = 160;
  localparam int Y_MAX_DEF = 120;

endpackage

// File: rtl/target_lfsr.sv
// rtl/target_lfsr.sv - free-running 16-bit Fibonacci LFSR; seeded on reset, never reaches zero
module target_lfsr
  import target_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  output logic [LFSR_W-1:0] STATE
);

  logic [LFSR_W-1:0] r_state;
  logic              w_feedback;

  assign w_feedback = ^(r_state & LFSR_TAPS);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= LFSR_SEED;
    end else begin
      r_state <= {r_state[LFSR_W-2:0], w_feedback};
    end
  end

  assign STATE = r_state;

endmodule

// File: rtl/target_generator.sv
// rtl/target_generator.sv - places pseudo-random targets inside the playfield and flags head hits
// Define TARGET_AVOID_HEAD_EN to also reject candidates equal to the last sampled head position.
module target_generator
  import target_pkg::*;
#(
  parameter int X_MAX = X_MAX_DEF,
  parameter int Y_MAX = Y_MAX_DEF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       GAME_ACTIVE,
  input  logic       HEAD_VALID,
  input  logic [7:0] HEAD_X,
  input  logic [6:0] HEAD_Y,
  output logic [7:0] TARGET_X,
  output logic [6:0] TARGET_Y,
  output logic       TARGET_VALID,
  output logic       REACHED_TARGET
);

  localparam logic [8:0] LP_X_MAX = 9'(X_MAX);
  localparam logic [7:0] LP_Y_MAX = 8'(Y_MAX);

  logic [LFSR_W-1:0] w_lfsr;
  logic [7:0]        w_cand_x;
  logic [6:0]        w_cand_y;
  logic              w_unused_msb;
  logic              w_in_range;
  logic              w_accept;
  logic              w_head_hit;

  state_t            r_state;
  logic [7:0]        r_target_x;
  logic [6:0]        r_target_y;
  logic              r_target_valid;
  logic              r_reached;

  target_lfsr u_lfsr (
    .CLK   (CLK),
    .RESET (RESET),
    .STATE (w_lfsr)
  );

  assign w_cand_x     = w_lfsr[7:0];
  assign w_cand_y     = w_lfsr[14:8];
  assign w_unused_msb = w_lfsr[15];
  assign w_in_range   = ({1'b0, w_cand_x} < LP_X_MAX) && ({1'b0, w_cand_y} < LP_Y_MAX);

`ifdef TARGET_AVOID_HEAD_EN
  logic [7:0] r_head_x;
  logic [6:0] r_head_y;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_head_x <= '0;
      r_head_y <= '0;
    end else if (HEAD_VALID) begin
      r_head_x <= HEAD_X;
      r_head_y <= HEAD_Y;
    end
  end

  assign w_accept = w_in_range && !((w_cand_x == r_head_x) && (w_cand_y == r_head_y));
`else
  assign w_accept = w_in_range;
`endif

  assign w_head_hit = HEAD_VALID && (HEAD_X == r_target_x) && (HEAD_Y == r_target_y);

  // Outputs are registered alongside the next state so they line up with it.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state        <= ST_IDLE;
      r_target_x     <= '0;
      r_target_y     <= '0;
      r_target_valid <= 1'b0;
      r_reached      <= 1'b0;
    end else begin
      r_target_valid <= 1'b0;
      r_reached      <= 1'b0;
      if (!GAME_ACTIVE) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_GEN;
          ST_GEN: begin
            if (w_accept) begin
              r_target_x     <= w_cand_x;
              r_target_y     <= w_cand_y;
              r_target_valid <= 1'b1;
              r_state        <= ST_ARMED;
            end
          end
          ST_ARMED: begin
            if (w_head_hit) begin
              r_reached <= 1'b1;
              r_state   <= ST_HIT;
            end else begin
              r_target_valid <= 1'b1;
            end
          end
          ST_HIT:  r_state <= ST_GEN;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign TARGET_X       = r_target_x;
  assign TARGET_Y       = r_target_y;
  assign TARGET_VALID   = r_target_valid;
  assign REACHED_TARGET = r_reached;

endmodule
